param_datapath: RTL and testbench

- Parametrised next-generation processor datapath. Generalises the two-scratch-register, 8-bit datapath to a WIDTH-bit datapath with a NUM_REGS-entry register file.
- Adds a multi-mode program counter with relative branch, a hardware stack pointer with occupancy checking, and an output register with a valid/ready handshake.
- Sits between the control FSM, the external ALU, RAM and ROM. The ALU is external: this block drives the operands and samples the result and flags.

---
 rtl/param_datapath.sv | 203 ++++++++++++++++++++
 tb/tb_param_datapath.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_datapath.sv
// param_datapath: parametrised processor datapath that sits between the
// control FSM, an external ALU, RAM and ROM.
//   clk, rst            : rising-edge clock, asynchronous active-low reset
//   bus1Select/bus2Select: source selects for the two internal buses
//   reg*                : NUM_REGS x WIDTH register file (2 read, 1 write)
//   aluOperandA/B, aluResult, aluFlags, flagRegister*: external ALU interface
//   IRLoad/IROut        : instruction register
//   memoryAccessRegisterLoad, addrSelect, address, toRAM, fromRAM, fromROM
//   pcMode              : program counter operation (hold/load/+1/+2/relative)
//   spPush/spPop/stackErrClear/stackCount/stackError: downward-growing stack
//   outputLoad/outValid/outReady/outData/outOverrun: valid/ready output reg
module param_datapath #(
  parameter int                WIDTH       = 8,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_REGS    = 4,
  parameter int                REG_SEL_W   = $clog2(NUM_REGS),
  parameter logic [ADDR_W-1:0] STACK_TOP   = {ADDR_W{1'b1}},
  parameter int                STACK_DEPTH = 16,
  parameter int                CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_W-1:0]    address,
  output logic [WIDTH-1:0]     toRAM,
  input  logic [WIDTH-1:0]     fromRAM,
  input  logic [WIDTH-1:0]     fromROM,
  input  logic [1:0]           bus1Select,
  input  logic [1:0]           bus2Select,
  input  logic [REG_SEL_W-1:0] regReadASel,
  input  logic [REG_SEL_W-1:0] regReadBSel,
  input  logic                 regWriteEn,
  input  logic [REG_SEL_W-1:0] regWriteSel,
  output logic [WIDTH-1:0]     aluOperandA,
  output logic [WIDTH-1:0]     aluOperandB,
  input  logic [WIDTH-1:0]     aluResult,
  input  logic [3:0]           aluFlags,
  input  logic                 flagRegisterLoad,
  output logic [3:0]           flagRegisterOut,
  input  logic                 IRLoad,
  output logic [WIDTH-1:0]     IROut,
  input  logic                 memoryAccessRegisterLoad,
  input  logic                 addrSelect,
  input  logic [2:0]           pcMode,
  input  logic                 spPush,
  input  logic                 spPop,
  input  logic                 stackErrClear,
  output logic [CNT_W-1:0]     stackCount,
  output logic                 stackError,
  input  logic                 outputLoad,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [WIDTH-1:0]     outData,
  output logic                 outOverrun
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [WIDTH-1:0]  ir_q, ir_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              serr_q, serr_d;
  logic [3:0]        flags_q, flags_d;
  logic [WIDTH-1:0]  odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic              ovr_q, ovr_d;
  logic [WIDTH-1:0]  bus1_s, bus2_s;
  logic              push_only_s, pop_only_s, xfer_s;

  // Bus multiplexers; PC and SP are zero-extended onto bus1.
  always_comb begin
    bus1_s = '0;
    bus2_s = '0;
    case (bus1Select)
      2'b00:   bus1_s = WIDTH'(pc_q);
      2'b01:   bus1_s = regs_q[regReadASel];
      2'b10:   bus1_s = regs_q[regReadBSel];
      2'b11:   bus1_s = WIDTH'(sp_q);
      default: bus1_s = '0;
    endcase
    case (bus2Select)
      2'b00:   bus2_s = aluResult;
      2'b01:   bus2_s = bus1_s;
      2'b10:   bus2_s = fromRAM;
      2'b11:   bus2_s = fromROM;
      default: bus2_s = '0;
    endcase
  end

  assign toRAM       = bus1_s;
  assign aluOperandA = regs_q[regReadASel];
  assign aluOperandB = regs_q[regReadBSel];
  assign address     = addrSelect ? sp_q : mar_q;

  // Next-state logic for PC, stack, IR/MAR/flags and the output register.
  always_comb begin
    ir_d     = ir_q;
    mar_d    = mar_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    serr_d   = serr_q;
    flags_d  = flags_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    ovr_d    = ovr_q;

    if (IRLoad) ir_d = bus2_s; else ir_d = ir_q;
    if (memoryAccessRegisterLoad) mar_d = bus2_s[ADDR_W-1:0]; else mar_d = mar_q;
    if (flagRegisterLoad) flags_d = aluFlags; else flags_d = flags_q;

    // Sign-extending bus2 and truncating to ADDR_W equals taking its low
    // ADDR_W bits, because ADDR_W <= WIDTH and the sum wraps anyway.
    case (pcMode)
      3'b000:  pc_d = pc_q;
      3'b001:  pc_d = bus2_s[ADDR_W-1:0];
      3'b010:  pc_d = pc_q + ADDR_W'(1);
      3'b011:  pc_d = pc_q + ADDR_W'(2);
      3'b100:  pc_d = pc_q + bus2_s[ADDR_W-1:0];
      default: pc_d = pc_q;
    endcase

    // Simultaneous push and pop cancel: neither branch below fires.
    push_only_s = spPush && !spPop;
    pop_only_s  = spPop && !spPush;
    if (push_only_s && (cnt_q < DEPTH_C)) begin
      sp_d  = sp_q - ADDR_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_only_s && (cnt_q != '0)) begin
      sp_d  = sp_q + ADDR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
    end
    // An overflow/underflow in the same cycle beats a clear.
    if ((push_only_s && (cnt_q >= DEPTH_C)) || (pop_only_s && (cnt_q == '0))) begin
      serr_d = 1'b1;
    end else if (stackErrClear) begin
      serr_d = 1'b0;
    end else begin
      serr_d = serr_q;
    end

    xfer_s = ovalid_q && outReady;
    if (outputLoad && (!ovalid_q || xfer_s)) begin
      odata_d  = bus1_s;
      ovalid_d = 1'b1;
    end else if (xfer_s) begin
      ovalid_d = 1'b0;
    end else begin
      ovalid_d = ovalid_q;
    end
    if (outputLoad && ovalid_q && !outReady) ovr_d = 1'b1; else ovr_d = ovr_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q     <= '0;
      mar_q    <= '0;
      pc_q     <= '0;
      sp_q     <= STACK_TOP;
      cnt_q    <= '0;
      serr_q   <= 1'b0;
      flags_q  <= 4'b0000;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      mar_q    <= mar_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
      serr_q   <= serr_d;
      flags_q  <= flags_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Register file: synchronous write, reads see the pre-edge contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (regWriteEn) begin
      regs_q[regWriteSel] <= bus2_s;
    end
  end

  assign IROut           = ir_q;
  assign flagRegisterOut = flags_q;
  assign stackCount      = cnt_q;
  assign stackError      = serr_q;
  assign outValid        = ovalid_q;
  assign outData         = odata_q;
  assign outOverrun      = ovr_q;

endmodule

// File: tb/tb_param_datapath.sv
// Directed testbench for param_datapath: an 8-bit instance (STACK_DEPTH=2)
// plus a 16-bit / ADDR_W=10 / 8-register instance for the parameter sweep.
module tb_param_datapath;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 8-bit instance signals
  logic [7:0] a_address, a_toRAM, a_fromRAM, a_fromROM, a_opA, a_opB, a_aluRes, a_IROut, a_outData;
  logic [1:0] a_b1s, a_b2s, a_rA, a_rB, a_wSel, a_cnt;
  logic       a_wEn, a_flagLd, a_irLd, a_marLd, a_addrSel, a_push, a_pop, a_errClr;
  logic       a_err, a_oLd, a_oValid, a_oReady, a_ovr;
  logic [3:0] a_flags, a_flagsOut;
  logic [2:0] a_pcMode;

  // 16-bit instance signals
  logic [9:0]  b_address;
  logic [15:0] b_toRAM, b_fromRAM, b_fromROM, b_opA, b_opB, b_aluRes, b_IROut, b_outData;
  logic [1:0]  b_b1s, b_b2s;
  logic [2:0]  b_rA, b_rB, b_wSel, b_pcMode;
  logic [4:0]  b_cnt;
  logic        b_wEn, b_flagLd, b_irLd, b_marLd, b_addrSel, b_push, b_pop, b_errClr;
  logic        b_err, b_oLd, b_oValid, b_oReady, b_ovr;
  logic [3:0]  b_flags, b_flagsOut;

  param_datapath #(.WIDTH(8), .ADDR_W(8), .NUM_REGS(4), .STACK_DEPTH(2)) u_dp8 (
    .clk(clk), .rst(rst), .address(a_address), .toRAM(a_toRAM), .fromRAM(a_fromRAM),
    .fromROM(a_fromROM), .bus1Select(a_b1s), .bus2Select(a_b2s), .regReadASel(a_rA),
    .regReadBSel(a_rB), .regWriteEn(a_wEn), .regWriteSel(a_wSel), .aluOperandA(a_opA),
    .aluOperandB(a_opB), .aluResult(a_aluRes), .aluFlags(a_flags),
    .flagRegisterLoad(a_flagLd), .flagRegisterOut(a_flagsOut), .IRLoad(a_irLd),
    .IROut(a_IROut), .memoryAccessRegisterLoad(a_marLd), .addrSelect(a_addrSel),
    .pcMode(a_pcMode), .spPush(a_push), .spPop(a_pop), .stackErrClear(a_errClr),
    .stackCount(a_cnt), .stackError(a_err), .outputLoad(a_oLd), .outValid(a_oValid),
    .outReady(a_oReady), .outData(a_outData), .outOverrun(a_ovr)
  );

  param_datapath #(.WIDTH(16), .ADDR_W(10), .NUM_REGS(8)) u_dp16 (
    .clk(clk), .rst(rst), .address(b_address), .toRAM(b_toRAM), .fromRAM(b_fromRAM),
    .fromROM(b_fromROM), .bus1Select(b_b1s), .bus2Select(b_b2s), .regReadASel(b_rA),
    .regReadBSel(b_rB), .regWriteEn(b_wEn), .regWriteSel(b_wSel), .aluOperandA(b_opA),
    .aluOperandB(b_opB), .aluResult(b_aluRes), .aluFlags(b_flags),
    .flagRegisterLoad(b_flagLd), .flagRegisterOut(b_flagsOut), .IRLoad(b_irLd),
    .IROut(b_IROut), .memoryAccessRegisterLoad(b_marLd), .addrSelect(b_addrSel),
    .pcMode(b_pcMode), .spPush(b_push), .spPop(b_pop), .stackErrClear(b_errClr),
    .stackCount(b_cnt), .stackError(b_err), .outputLoad(b_oLd), .outValid(b_oValid),
    .outReady(b_oReady), .outData(b_outData), .outOverrun(b_ovr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_fromRAM = 8'h00; a_fromROM = 8'h00; a_aluRes = 8'h00; a_flags = 4'h0;
    a_b1s = 2'b00; a_b2s = 2'b00; a_rA = 2'd0; a_rB = 2'd0; a_wSel = 2'd0;
    a_wEn = 1'b0; a_flagLd = 1'b0; a_irLd = 1'b0; a_marLd = 1'b0; a_addrSel = 1'b0;
    a_pcMode = 3'b000; a_push = 1'b0; a_pop = 1'b0; a_errClr = 1'b0;
    a_oLd = 1'b0; a_oReady = 1'b0;
  endtask

  task automatic idle_b();
    b_fromRAM = 16'h0000; b_fromROM = 16'h0000; b_aluRes = 16'h0000; b_flags = 4'h0;
    b_b1s = 2'b00; b_b2s = 2'b00; b_rA = 3'd0; b_rB = 3'd0; b_wSel = 3'd0;
    b_wEn = 1'b0; b_flagLd = 1'b0; b_irLd = 1'b0; b_marLd = 1'b0; b_addrSel = 1'b0;
    b_pcMode = 3'b000; b_push = 1'b0; b_pop = 1'b0; b_errClr = 1'b0;
    b_oLd = 1'b0; b_oReady = 1'b0;
  endtask

  // Write an 8-bit value into the small instance's register file via fromROM.
  task automatic write_reg_a(input logic [1:0] idx, input logic [7:0] val);
    a_b2s = 2'b11; a_fromROM = val; a_wSel = idx; a_wEn = 1'b1;
    tick();
    a_wEn = 1'b0;
  endtask

  initial begin
    idle_a();
    idle_b();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset state
    a_b1s = 2'b11; #1;
    check_eq("rst_sp", a_toRAM, 8'hFF);
    a_b1s = 2'b00; #1;
    check_eq("rst_pc", a_toRAM, 8'h00);
    check_eq("rst_valid", a_oValid, 1'b0);
    check_eq("rst_cnt", a_cnt, 2'd0);
    check_eq("rst_err", a_err, 1'b0);

    // Asynchronous reset in the middle of a push
    a_push = 1'b1; a_b1s = 2'b11;
    tick();
    check_eq("push_pre_rst", a_toRAM, 8'hFE);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_sp", a_toRAM, 8'hFF);
    check_eq("async_rst_cnt", a_cnt, 2'd0);
    a_push = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Register file write/read, no bypass
    write_reg_a(2'd2, 8'hA5);
    write_reg_a(2'd3, 8'h3C);
    a_rA = 2'd2; a_rB = 2'd3; #1;
    check_eq("reg_a", a_opA, 8'hA5);
    check_eq("reg_b", a_opB, 8'h3C);
    a_fromROM = 8'h77; a_wSel = 2'd2; a_wEn = 1'b1; #1;
    check_eq("reg_nobypass", a_opA, 8'hA5);
    tick();
    a_wEn = 1'b0; #1;
    check_eq("reg_after_wr", a_opA, 8'h77);

    // PC modes
    a_b1s = 2'b00; a_b2s = 2'b11; a_fromROM = 8'hFE; a_pcMode = 3'b001;
    tick();
    check_eq("pc_load", a_toRAM, 8'hFE);
    a_pcMode = 3'b011;
    tick();
    check_eq("pc_plus2_wrap", a_toRAM, 8'h00);
    a_pcMode = 3'b100; a_fromROM = 8'hFC;
    tick();
    check_eq("pc_rel_neg", a_toRAM, 8'hFC);
    a_pcMode = 3'b010;
    tick();
    check_eq("pc_inc", a_toRAM, 8'hFD);
    a_pcMode = 3'b111;
    tick();
    check_eq("pc_unlisted_hold", a_toRAM, 8'hFD);
    a_pcMode = 3'b000;

    // Stack, depth 2
    a_b1s = 2'b11;
    a_push = 1'b1; tick(); tick();
    check_eq("push2_sp", a_toRAM, 8'hFD);
    check_eq("push2_cnt", a_cnt, 2'd2);
    check_eq("push2_err", a_err, 1'b0);
    tick();
    check_eq("overflow_sp", a_toRAM, 8'hFD);
    check_eq("overflow_cnt", a_cnt, 2'd2);
    check_eq("overflow_err", a_err, 1'b1);
    a_pop = 1'b1; tick();
    check_eq("pushpop_sp", a_toRAM, 8'hFD);
    check_eq("pushpop_cnt", a_cnt, 2'd2);
    a_push = 1'b0;
    tick(); tick();
    check_eq("pop2_sp", a_toRAM, 8'hFF);
    check_eq("pop2_cnt", a_cnt, 2'd0);
    tick();
    check_eq("underflow_sp", a_toRAM, 8'hFF);
    check_eq("underflow_err", a_err, 1'b1);
    a_pop = 1'b0; a_errClr = 1'b1; tick();
    check_eq("err_clear", a_err, 1'b0);
    a_pop = 1'b1; tick();
    check_eq("err_beats_clear", a_err, 1'b1);
    a_pop = 1'b0; a_errClr = 1'b0;
    a_addrSel = 1'b1; #1;
    check_eq("addr_sp", a_address, 8'hFF);
    a_addrSel = 1'b0;

    // Output handshake, bus1 = regA(reg0)
    a_rA = 2'd0; write_reg_a(2'd0, 8'h11);
    a_b1s = 2'b01; a_oLd = 1'b1; a_oReady = 1'b0; tick();
    check_eq("out_load_valid", a_oValid, 1'b1);
    check_eq("out_load_data", a_outData, 8'h11);
    check_eq("out_no_ovr", a_ovr, 1'b0);
    a_oLd = 1'b0; write_reg_a(2'd0, 8'h22);
    a_oLd = 1'b1; tick();
    check_eq("out_refused_data", a_outData, 8'h11);
    check_eq("out_overrun", a_ovr, 1'b1);
    a_oLd = 1'b0; write_reg_a(2'd0, 8'h33);
    a_oLd = 1'b1; a_oReady = 1'b1; tick();
    check_eq("out_xfer_load_data", a_outData, 8'h33);
    check_eq("out_xfer_load_valid", a_oValid, 1'b1);
    a_oLd = 1'b0; tick();
    check_eq("out_drain", a_oValid, 1'b0);
    check_eq("out_ovr_sticky", a_ovr, 1'b1);
    a_oReady = 1'b0;

    // IR, MAR and flags all load from the same bus2 in one cycle
    a_b2s = 2'b11; a_fromROM = 8'h5A; a_flags = 4'b1010;
    a_irLd = 1'b1; a_marLd = 1'b1; a_flagLd = 1'b1; tick();
    check_eq("ir_rom", a_IROut, 8'h5A);
    check_eq("mar_rom", a_address, 8'h5A);
    check_eq("flags", a_flagsOut, 4'b1010);
    a_flagLd = 1'b0; a_marLd = 1'b0;
    a_b2s = 2'b00; a_aluRes = 8'hC3; tick();
    check_eq("ir_alu", a_IROut, 8'hC3);
    a_irLd = 1'b0; a_b2s = 2'b10; a_fromRAM = 8'h44; a_marLd = 1'b1; tick();
    check_eq("mar_ram", a_address, 8'h44);
    a_marLd = 1'b0;

    // Parameter sweep instance
    b_b1s = 2'b11; #1;
    check_eq("w16_sp_zext", b_toRAM, 16'h03FF);
    b_b1s = 2'b00; b_b2s = 2'b11; b_fromROM = 16'hFFFF; b_pcMode = 3'b100; tick();
    check_eq("w16_pc_rel", b_toRAM, 16'h03FF);
    b_pcMode = 3'b000; b_fromROM = 16'hBEEF; b_wSel = 3'd7; b_wEn = 1'b1; tick();
    b_wEn = 1'b0; b_rA = 3'd7; #1;
    check_eq("w16_reg7", b_opA, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
